spio_uart_pkt_rx: RTL and testbench

SPIO_UART_PKT_RX -- requirements
Module: spio_uart_pkt_rx

---
 rtl/spio_uart_pkt_rx_pkg.sv | 15 +
 rtl/spio_uart_pkt_rx.sv | 129 ++++++++++++
 tb/tb_spio_uart_pkt_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spio_uart_pkt_rx_pkg.sv
// Shared constants for the SpiNNaker UART packet receive path: packet
// geometry, framing byte values and the receiver FSM encodings.
package spio_uart_pkt_rx_pkg;

  localparam int unsigned PKT_LEN   = 72;
  localparam int unsigned PKT_BYTES = PKT_LEN / 8;

  localparam logic [7:0] SYNC_MARKER = 8'hFF;
  localparam logic [7:0] NULL_BYTE   = 8'h00;

  localparam logic [1:0] ST_UNSYNC    = 2'd0;
  localparam logic [1:0] ST_WAIT_MARK = 2'd1;
  localparam logic [1:0] ST_SYNCED    = 2'd2;

endpackage

// File: rtl/spio_uart_pkt_rx.sv
// Byte-stream to SpiNNaker packet framer: locks onto a run of null bytes plus
// a sync marker, then assembles 9-byte packets and drops those with bad parity.
module spio_uart_pkt_rx
  import spio_uart_pkt_rx_pkg::*;
#(
  parameter int unsigned SYNC_ZEROS   = 9,
  parameter int unsigned ERR_CNT_BITS = 8
) (
  input  logic                    CLK_IN,
  input  logic                    RESET_IN,
  input  logic [7:0]              BYTE_DATA_IN,
  input  logic                    BYTE_VLD_IN,
  output logic [PKT_LEN-1:0]      PKT_DATA_OUT,
  output logic                    PKT_VLD_OUT,
  output logic                    PARITY_ERR_OUT,
  output logic [ERR_CNT_BITS-1:0] ERR_COUNT_OUT,
  output logic                    SYNCHRONISING_OUT
);

  localparam int unsigned ZC_W = $clog2(SYNC_ZEROS + 1);

  logic [1:0]              state_q, state_d;
  logic [ZC_W-1:0]         zc_q, zc_d;
  logic [3:0]              idx_q, idx_d;
  logic [PKT_LEN-9:0]      asm_q, asm_d;
  logic [PKT_LEN-1:0]      pkt_data_q, pkt_data_d;
  logic                    pkt_vld_q, pkt_vld_d;
  logic                    parity_err_q, parity_err_d;
  logic [ERR_CNT_BITS-1:0] err_count_q, err_count_d;
  logic                    sync_q, sync_d;
  logic [PKT_LEN-1:0]      full_pkt;

  // Earlier bytes sit in asm_q (byte 0 lowest); the final byte completes it.
  assign full_pkt = {BYTE_DATA_IN, asm_q};

  always_comb begin
    state_d      = state_q;
    zc_d         = zc_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    pkt_data_d   = pkt_data_q;
    pkt_vld_d    = 1'b0;
    parity_err_d = 1'b0;
    err_count_d  = err_count_q;

    if (BYTE_VLD_IN) begin
      case (state_q)
        ST_UNSYNC: begin
          if (BYTE_DATA_IN == NULL_BYTE) begin
            if (zc_q == ZC_W'(SYNC_ZEROS - 1)) begin
              state_d = ST_WAIT_MARK;
              zc_d    = '0;
            end else begin
              zc_d = zc_q + ZC_W'(1);
            end
          end else begin
            zc_d = '0;
          end
        end
        ST_WAIT_MARK: begin
          if (BYTE_DATA_IN == SYNC_MARKER) begin
            state_d = ST_SYNCED;
            idx_d   = '0;
          end else if (BYTE_DATA_IN != NULL_BYTE) begin
            state_d = ST_UNSYNC;
            zc_d    = '0;
          end
        end
        ST_SYNCED: begin
          asm_d = {BYTE_DATA_IN, asm_q[PKT_LEN-9:8]};
          if (idx_q == 4'(PKT_BYTES - 1)) begin
            idx_d = '0;
            // An all-zero packet is the transmitter re-announcing sync.
            if (full_pkt == '0) begin
              state_d = ST_WAIT_MARK;
            end else if (^full_pkt) begin
              pkt_data_d = full_pkt;
              pkt_vld_d  = 1'b1;
            end else begin
              parity_err_d = 1'b1;
              if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_CNT_BITS'(1);
              end
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_UNSYNC;
          zc_d    = '0;
        end
      endcase
    end

    sync_d = (state_d != ST_SYNCED);
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q      <= ST_UNSYNC;
      zc_q         <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      pkt_data_q   <= '0;
      pkt_vld_q    <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
      sync_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      zc_q         <= zc_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      pkt_data_q   <= pkt_data_d;
      pkt_vld_q    <= pkt_vld_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
      sync_q       <= sync_d;
    end
  end

  assign PKT_DATA_OUT      = pkt_data_q;
  assign PKT_VLD_OUT       = pkt_vld_q;
  assign PARITY_ERR_OUT    = parity_err_q;
  assign ERR_COUNT_OUT     = err_count_q;
  assign SYNCHRONISING_OUT = sync_q;

endmodule

// File: tb/tb_spio_uart_pkt_rx.sv
// Randomised bench for spio_uart_pkt_rx against a byte-stream reference model.
module tb_spio_uart_pkt_rx;

  localparam int SZ = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bdata = 8'h00;
  logic        bvld = 1'b0;
  logic [71:0] pkt_data;
  logic        pkt_vld;
  logic        par_err;
  logic [7:0]  err_cnt;
  logic        synching;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_mode = 0;   // 0 hunting zeros, 1 awaiting marker, 2 locked
  int          m_zeros = 0;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_ecnt = 8'd0;
  logic [71:0] m_last = '0;
  logic        m_vld = 1'b0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  spio_uart_pkt_rx #(
    .SYNC_ZEROS   (SZ),
    .ERR_CNT_BITS (8)
  ) dut (
    .CLK_IN            (clk),
    .RESET_IN          (rst),
    .BYTE_DATA_IN      (bdata),
    .BYTE_VLD_IN       (bvld),
    .PKT_DATA_OUT      (pkt_data),
    .PKT_VLD_OUT       (pkt_vld),
    .PARITY_ERR_OUT    (par_err),
    .ERR_COUNT_OUT     (err_cnt),
    .SYNCHRONISING_OUT (synching)
  );

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_zeros = 0; m_bytes.delete();
    m_ecnt = 8'd0; m_last = '0; m_vld = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [71:0] p;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (m_mode == 0) begin
      if (b == 8'h00) begin
        m_zeros++;
        if (m_zeros == SZ) begin m_mode = 1; m_zeros = 0; end
      end else m_zeros = 0;
    end else if (m_mode == 1) begin
      if (b == 8'hFF) begin m_mode = 2; m_bytes.delete(); end
      else if (b != 8'h00) begin m_mode = 0; m_zeros = 0; end
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 9) begin
        p = '0;
        for (int i = 0; i < 9; i++) p = p | (72'(m_bytes[i]) << (8 * i));
        m_bytes.delete();
        if (p == '0) m_mode = 1;
        else if ($countones(p) % 2 == 1) begin m_vld = 1'b1; m_last = p; end
        else begin
          m_err = 1'b1;
          if (m_ecnt != 8'd255) m_ecnt = m_ecnt + 8'd1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph, input logic exp_vld, input logic exp_err);
    chk({ph, "_vld"}, 72'(pkt_vld), 72'(exp_vld));
    chk({ph, "_perr"}, 72'(par_err), 72'(exp_err));
    chk({ph, "_ecnt"}, 72'(err_cnt), 72'(m_ecnt));
    chk({ph, "_sync"}, 72'(synching), 72'(m_mode != 2));
    chk({ph, "_data"}, pkt_data, m_last);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int idles;
    @(negedge clk);
    bdata = b;
    bvld  = 1'b1;
    @(posedge clk);
    #1 bvld = 1'b0;
    bdata = 8'($urandom);
    model_byte(b);
    check_outputs("byte", m_vld, m_err);
    idles = $urandom_range(0, 2);
    repeat (idles) begin
      @(posedge clk);
      #1 check_outputs("idle", 1'b0, 1'b0);
    end
  endtask

  task automatic send_sync();
    repeat (SZ) send_byte(8'h00);
    send_byte(8'hFF);
  endtask

  // kind: 0 good (odd parity), 1 bad (even, non-null)
  task automatic send_packet(input int kind);
    logic [7:0] b[9];
    int ones;
    do begin
      ones = 0;
      for (int i = 0; i < 9; i++) begin
        b[i] = 8'($urandom);
        ones += $countones(b[i]);
      end
      if ((ones % 2) != (kind == 0 ? 1 : 0)) b[8][0] = ~b[8][0];
      ones = 0;
      for (int i = 0; i < 9; i++) ones += $countones(b[i]);
    end while (ones == 0);
    for (int i = 0; i < 9; i++) send_byte(b[i]);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bvld = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1 check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    apply_reset(3);

    // one zero short: must still be hunting after the marker
    repeat (SZ - 1) send_byte(8'h00);
    send_byte(8'hFF);
    chk("short_run_sync", 72'(synching), 72'd1);
    send_sync();
    chk("synced_after_marker", 72'(synching), 72'd0);

    // packet 72'h01
    send_byte(8'h01);
    repeat (8) send_byte(8'h00);
    chk("pkt01_data", pkt_data, 72'h01);

    // even-parity packet while re-announcing sync
    send_sync();
    send_byte(8'h03);
    repeat (8) send_byte(8'h00);
    chk("even_pkt_count", 72'(err_cnt), 72'd1);

    // null packet while locked, then marker, then good packet
    send_sync();
    send_packet(0);

    // reset mid-packet
    repeat (4) send_byte(8'($urandom));
    apply_reset(2);
    send_sync();
    send_packet(0);

    // random mix of good, bad and resync traffic
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 5);
      if (k == 0) send_sync();
      else if (k == 1) send_packet(1);
      else send_packet(0);
    end

    // counter saturation
    for (int n = 0; n < 300; n++) send_packet(1);
    chk("ecnt_saturated", 72'(err_cnt), 72'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
